// File: rtl/sd_block_arbiter.sv
// ---------------------------------------------------------------------------
// sd_block_arbiter
//
// Shares the single SD block interface of the MiST IO controller between two
// requesters (typically the 1541 track loader as client 0 and a tape/PRG
// image loader as client 1). One block transfer is in flight at a time, the
// grant is round-robin and is held for the whole block. The LBA is latched
// per grant, byte strobes are routed to the owner only, bytes are counted
// and the owner receives a one-cycle done pulse at the end of its block.
//
// Optional build macro: SD_ARB_TIMEOUT_EN
//   When defined, adds parameter TIMEOUT_CYCLES and output err. A watchdog
//   aborts a transfer stalled in ISSUE/XFER, pulsing err together with the
//   owner's done. When undefined the arbiter waits indefinitely.
//
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   cN_lba              block address from client N (N = 0,1)
//   cN_rd, cN_wr        request levels, held until cN_done
//   cN_dout             write data from client N
//   cN_din              read data to client N (always a copy of io_din)
//   cN_din_strobe       read byte valid, asserted for the owner only
//   cN_dout_strobe      write byte consumed, asserted for the owner only
//   cN_done             one-cycle pulse at the end of client N's block
//   io_lba              latched LBA to the IO controller
//   io_rd, io_wr        block request to the IO controller
//   io_ack              IO controller acknowledge, high during the transfer
//   io_din              read byte from the IO controller
//   io_din_strobe       read byte valid
//   io_dout             owner's write data, 0 when idle
//   io_dout_strobe      write byte taken
//   busy                high whenever the arbiter is not idle
//   owner               current or last granted client
//   err                 (SD_ARB_TIMEOUT_EN only) timeout abort pulse
// ---------------------------------------------------------------------------
module sd_block_arbiter #(
  parameter int BLOCK_BYTES = 512,
  parameter int CNT_W       = 10
`ifdef SD_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1 << 24
`endif
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic [31:0] c0_lba,
  input  logic        c0_rd,
  input  logic        c0_wr,
  input  logic [7:0]  c0_dout,
  output logic [7:0]  c0_din,
  output logic        c0_din_strobe,
  output logic        c0_dout_strobe,
  output logic        c0_done,

  input  logic [31:0] c1_lba,
  input  logic        c1_rd,
  input  logic        c1_wr,
  input  logic [7:0]  c1_dout,
  output logic [7:0]  c1_din,
  output logic        c1_din_strobe,
  output logic        c1_dout_strobe,
  output logic        c1_done,

  output logic [31:0] io_lba,
  output logic        io_rd,
  output logic        io_wr,
  input  logic        io_ack,
  input  logic [7:0]  io_din,
  input  logic        io_din_strobe,
  output logic [7:0]  io_dout,
  input  logic        io_dout_strobe,

  output logic        busy,
  output logic        owner
`ifdef SD_ARB_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] BLOCK_LIM = CNT_W'(BLOCK_BYTES);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              op_rd_q, op_rd_d;
  logic [31:0]       lba_q, lba_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              io_rd_q, io_rd_d;
  logic              io_wr_q, io_wr_d;

  logic              req0, req1;
  logic              pick;
  logic              room;
  logic              fwd_rd, fwd_wr, fwd;
  logic              done_pulse;

`ifdef SD_ARB_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              err_q, err_d;
  logic              tmo_hit;
`endif

  assign req0 = c0_rd | c0_wr;
  assign req1 = c1_rd | c1_wr;

  // Strobes are only forwarded while a block is in flight and the block is
  // not yet full; anything else from the IO controller is silently dropped.
  assign room   = (cnt_q < BLOCK_LIM);
  assign fwd_rd = (state_q == ST_XFER) &&  op_rd_q && io_din_strobe  && room;
  assign fwd_wr = (state_q == ST_XFER) && !op_rd_q && io_dout_strobe && room;
  assign fwd    = fwd_rd | fwd_wr;

  // State register and all registered datapath; reset abandons any block in
  // flight without a done pulse and biases the first grant to client 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b1;
      op_rd_q   <= 1'b1;
      lba_q     <= '0;
      cnt_q     <= '0;
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      op_rd_q   <= op_rd_d;
      lba_q     <= lba_d;
      cnt_q     <= cnt_d;
      io_rd_q   <= io_rd_d;
      io_wr_q   <= io_wr_d;
`ifdef SD_ARB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // Next-state logic. Grant and LBA/op capture happen only in IDLE, so any
  // request or LBA change while a block is in flight cannot disturb it.
  // io_rd/io_wr are registered in ISSUE, giving two cycles from request to
  // the IO controller seeing the request.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_rd_d = op_rd_q;
    lba_d   = lba_q;
    cnt_d   = cnt_q;
    io_rd_d = io_rd_q;
    io_wr_d = io_wr_q;
    pick    = owner_q;

    case (state_q)
      ST_IDLE: begin
        io_rd_d = 1'b0;
        io_wr_d = 1'b0;
        if (req0 || req1) begin
          // Contention goes to the client that did not have the last grant.
          pick    = (req0 && req1) ? !owner_q : req1;
          owner_d = pick;
          lba_d   = pick ? c1_lba : c0_lba;
          // rd wins over wr when a client raises both.
          op_rd_d = pick ? c1_rd : c0_rd;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (io_ack) begin
          io_rd_d = 1'b0;
          io_wr_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_XFER;
        end else begin
          io_rd_d = op_rd_q;
          io_wr_d = !op_rd_q;
        end
      end

      ST_XFER: begin
        if (fwd) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!io_ack) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        io_rd_d = 1'b0;
        io_wr_d = 1'b0;
      end
    endcase

`ifdef SD_ARB_TIMEOUT_EN
    // Watchdog: only fires if nothing else moved the FSM or forwarded a byte
    // this cycle; the abort drops the IO request and returns straight to IDLE.
    tmo_hit = ((state_q == ST_ISSUE) || (state_q == ST_XFER)) &&
              (state_d == state_q) && !fwd && (tmo_cnt_q == TMO_LAST);
    err_d   = tmo_hit;
    if (tmo_hit) begin
      state_d = ST_IDLE;
      io_rd_d = 1'b0;
      io_wr_d = 1'b0;
    end

    if ((state_d != state_q) || fwd ||
        !((state_q == ST_ISSUE) || (state_q == ST_XFER))) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
`endif
  end

`ifdef SD_ARB_TIMEOUT_EN
  // A timeout abort completes the block from the client's point of view.
  assign done_pulse = (state_q == ST_DONE) || err_q;
  assign err        = err_q;
`else
  assign done_pulse = (state_q == ST_DONE);
`endif

  assign c0_din         = io_din;
  assign c1_din         = io_din;
  assign c0_din_strobe  = fwd_rd && !owner_q;
  assign c1_din_strobe  = fwd_rd &&  owner_q;
  assign c0_dout_strobe = fwd_wr && !owner_q;
  assign c1_dout_strobe = fwd_wr &&  owner_q;
  assign c0_done        = done_pulse && !owner_q;
  assign c1_done        = done_pulse &&  owner_q;

  assign io_lba  = lba_q;
  assign io_rd   = io_rd_q;
  assign io_wr   = io_wr_q;
  assign io_dout = (state_q == ST_IDLE) ? 8'h00 : (owner_q ? c1_dout : c0_dout);

  assign busy  = (state_q != ST_IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_block_arbiter
//
// Self-checking bench for sd_block_arbiter. A table of per-cycle vectors
// walks a short read by client 0, a short write by client 1 and a contended
// request; hand-written sequences cover full blocks, overrun, short blocks,
// reset mid-transfer, alternating grants and (with SD_ARB_TIMEOUT_EN) the
// watchdog abort.
// ---------------------------------------------------------------------------
module tb_sd_block_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] c0_lba, c1_lba;
  logic        c0_rd, c0_wr, c1_rd, c1_wr;
  logic [7:0]  c0_dout, c1_dout;
  logic [7:0]  c0_din, c1_din;
  logic        c0_din_strobe, c1_din_strobe;
  logic        c0_dout_strobe, c1_dout_strobe;
  logic        c0_done, c1_done;
  logic [31:0] io_lba;
  logic        io_rd, io_wr, io_ack;
  logic [7:0]  io_din, io_dout;
  logic        io_din_strobe, io_dout_strobe;
  logic        busy, owner;
`ifdef SD_ARB_TIMEOUT_EN
  logic        err;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Clock generation, 10 ns period.
  always #5 clk = ~clk;

  sd_block_arbiter #(
    .BLOCK_BYTES(512),
    .CNT_W(10)
`ifdef SD_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .c0_lba(c0_lba),
    .c0_rd(c0_rd),
    .c0_wr(c0_wr),
    .c0_dout(c0_dout),
    .c0_din(c0_din),
    .c0_din_strobe(c0_din_strobe),
    .c0_dout_strobe(c0_dout_strobe),
    .c0_done(c0_done),
    .c1_lba(c1_lba),
    .c1_rd(c1_rd),
    .c1_wr(c1_wr),
    .c1_dout(c1_dout),
    .c1_din(c1_din),
    .c1_din_strobe(c1_din_strobe),
    .c1_dout_strobe(c1_dout_strobe),
    .c1_done(c1_done),
    .io_lba(io_lba),
    .io_rd(io_rd),
    .io_wr(io_wr),
    .io_ack(io_ack),
    .io_din(io_din),
    .io_din_strobe(io_din_strobe),
    .io_dout(io_dout),
    .io_dout_strobe(io_dout_strobe),
    .busy(busy),
    .owner(owner)
`ifdef SD_ARB_TIMEOUT_EN
    ,
    .err(err)
`endif
  );

  // One cycle of stimulus and the outputs expected within that cycle.
  typedef struct {
    logic        c0_rd, c0_wr, c1_rd, c1_wr, ack, dstb, wstb;
    logic        io_rd, io_wr, busy, own;
    logic        c0ds, c1ds, c0ws, c1ws, c0dn, c1dn;
    logic [31:0] lba;
    logic [7:0]  dout;
  } vec_t;

  vec_t vecs[20];

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges and check the reset values while still in reset.
  task automatic resetDut();
    reset_n = 1'b0;
    c0_rd = 0; c0_wr = 0; c1_rd = 0; c1_wr = 0;
    c0_lba = 32'h0000_1234; c1_lba = 32'h0000_0005;
    c0_dout = 8'h3C; c1_dout = 8'hA5;
    io_ack = 0; io_din = 8'h00; io_din_strobe = 0; io_dout_strobe = 0;
    tick();
    tick();
    checkOutput("rst_io_rd", io_rd, 0);
    checkOutput("rst_io_wr", io_wr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 1);
    checkOutput("rst_io_lba", io_lba, 0);
    checkOutput("rst_done", {c0_done, c1_done}, 0);
    checkOutput("rst_io_dout", io_dout, 0);
`ifdef SD_ARB_TIMEOUT_EN
    checkOutput("rst_err", err, 0);
`endif
    reset_n = 1'b1;
  endtask

  // Apply one vector, check mid-cycle, then advance to the next cycle.
  task automatic applyStimulus(input int idx, input vec_t v);
    logic [7:0] din_val;
    din_val = 8'(idx * 7 + 3);
    c0_rd = v.c0_rd; c0_wr = v.c0_wr; c1_rd = v.c1_rd; c1_wr = v.c1_wr;
    io_ack = v.ack; io_din_strobe = v.dstb; io_dout_strobe = v.wstb;
    io_din = din_val;
    #1;
    checkOutput($sformatf("v%0d_io_rd", idx), io_rd, v.io_rd);
    checkOutput($sformatf("v%0d_io_wr", idx), io_wr, v.io_wr);
    checkOutput($sformatf("v%0d_busy", idx), busy, v.busy);
    checkOutput($sformatf("v%0d_owner", idx), owner, v.own);
    checkOutput($sformatf("v%0d_c0_din_strobe", idx), c0_din_strobe, v.c0ds);
    checkOutput($sformatf("v%0d_c1_din_strobe", idx), c1_din_strobe, v.c1ds);
    checkOutput($sformatf("v%0d_c0_dout_strobe", idx), c0_dout_strobe, v.c0ws);
    checkOutput($sformatf("v%0d_c1_dout_strobe", idx), c1_dout_strobe, v.c1ws);
    checkOutput($sformatf("v%0d_c0_done", idx), c0_done, v.c0dn);
    checkOutput($sformatf("v%0d_c1_done", idx), c1_done, v.c1dn);
    checkOutput($sformatf("v%0d_io_lba", idx), io_lba, v.lba);
    checkOutput($sformatf("v%0d_io_dout", idx), io_dout, v.dout);
    checkOutput($sformatf("v%0d_din_copy", idx), {c0_din, c1_din}, {din_val, din_val});
    tick();
  endtask

  // Wait (bounded) for io_rd/io_wr, then acknowledge; returns inside XFER.
  task automatic waitIssue(output logic own);
    bit found;
    found = 0;
    own = 1'bx;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (io_rd || io_wr) begin
        found = 1;
        own = owner;
      end
      tick();
    end
    checkOutput("issue_seen", found, 1);
    io_ack = 1;
    tick();
  endtask

  // Drive n strobes of one kind and count the forwarded ones per client.
  task automatic strobeN(input int n, input bit rd, output int cnt0, output int cnt1);
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < n; i++) begin
      if (rd) io_din_strobe = 1; else io_dout_strobe = 1;
      #1;
      if (rd) begin
        cnt0 += int'(c0_din_strobe);
        cnt1 += int'(c1_din_strobe);
      end else begin
        cnt0 += int'(c0_dout_strobe);
        cnt1 += int'(c1_dout_strobe);
      end
      tick();
    end
    io_din_strobe = 0;
    io_dout_strobe = 0;
  endtask

  // Drop ack; one cycle later sample the done outputs.
  task automatic finishBlock(output logic d0, output logic d1);
    io_ack = 0;
    tick();
    #1;
    d0 = c0_done;
    d1 = c1_done;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic own, d0, d1;
    int   n0, n1;

    //           c0r c0w c1r c1w ack ds ws | rd wr by ow c0ds c1ds c0ws c1ws c0dn c1dn lba dout
    vecs[0]  = '{1,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,0,0, 32'h0,    8'h00};
    vecs[1]  = '{1,0,0,0,0,0,0, 0,0,1,0, 0,0,0,0,0,0, 32'h1234, 8'h3C};
    vecs[2]  = '{1,0,0,0,0,0,0, 1,0,1,0, 0,0,0,0,0,0, 32'h1234, 8'h3C};
    vecs[3]  = '{1,0,0,0,1,0,0, 1,0,1,0, 0,0,0,0,0,0, 32'h1234, 8'h3C};
    vecs[4]  = '{1,0,0,0,1,1,0, 0,0,1,0, 1,0,0,0,0,0, 32'h1234, 8'h3C};
    vecs[5]  = '{1,0,0,0,1,0,0, 0,0,1,0, 0,0,0,0,0,0, 32'h1234, 8'h3C};
    vecs[6]  = '{1,0,0,0,1,1,1, 0,0,1,0, 1,0,0,0,0,0, 32'h1234, 8'h3C};
    vecs[7]  = '{1,0,0,0,0,0,0, 0,0,1,0, 0,0,0,0,0,0, 32'h1234, 8'h3C};
    vecs[8]  = '{0,0,0,1,0,0,0, 0,0,1,0, 0,0,0,0,1,0, 32'h1234, 8'h3C};
    vecs[9]  = '{0,0,0,1,0,1,0, 0,0,0,0, 0,0,0,0,0,0, 32'h1234, 8'h00};
    vecs[10] = '{0,0,0,1,0,0,0, 0,0,1,1, 0,0,0,0,0,0, 32'h5,    8'hA5};
    vecs[11] = '{0,0,0,1,0,0,0, 0,1,1,1, 0,0,0,0,0,0, 32'h5,    8'hA5};
    vecs[12] = '{0,0,0,1,1,0,0, 0,1,1,1, 0,0,0,0,0,0, 32'h5,    8'hA5};
    vecs[13] = '{0,0,0,1,1,0,1, 0,0,1,1, 0,0,0,1,0,0, 32'h5,    8'hA5};
    vecs[14] = '{0,0,0,1,1,1,0, 0,0,1,1, 0,0,0,0,0,0, 32'h5,    8'hA5};
    vecs[15] = '{0,0,0,1,0,0,0, 0,0,1,1, 0,0,0,0,0,0, 32'h5,    8'hA5};
    vecs[16] = '{0,0,0,0,0,0,0, 0,0,1,1, 0,0,0,0,0,1, 32'h5,    8'hA5};
    vecs[17] = '{1,1,1,0,0,0,0, 0,0,0,1, 0,0,0,0,0,0, 32'h5,    8'h00};
    vecs[18] = '{1,1,1,0,0,0,0, 0,0,1,0, 0,0,0,0,0,0, 32'h1234, 8'h3C};
    vecs[19] = '{1,1,1,0,0,0,0, 1,0,1,0, 0,0,0,0,0,0, 32'h1234, 8'h3C};

    $display("[TB] reset and vector table");
    resetDut();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i, vecs[i]);
    end

    $display("[TB] client 0 full read with 520 strobes");
    resetDut();
    c0_rd = 1;
    waitIssue(own);
    checkOutput("full_rd_owner", own, 0);
    checkOutput("full_rd_lba", io_lba, 32'h0000_1234);
    c0_lba = 32'hDEAD_BEEF;
    c1_rd = 1;
    #1;
    checkOutput("lba_stable", io_lba, 32'h0000_1234);
    checkOutput("owner_stable", owner, 0);
    c1_rd = 0;
    c0_lba = 32'h0000_1234;
    strobeN(520, 1, n0, n1);
    checkOutput("full_rd_c0_cnt", n0, 512);
    checkOutput("full_rd_c1_cnt", n1, 0);
    finishBlock(d0, d1);
    checkOutput("full_rd_c0_done", d0, 1);
    checkOutput("full_rd_c1_done", d1, 0);
    c0_rd = 0;
    tick();
    checkOutput("done_one_cycle", c0_done, 0);

    $display("[TB] client 1 full write");
    c1_wr = 1;
    waitIssue(own);
    checkOutput("full_wr_owner", own, 1);
    checkOutput("full_wr_lba", io_lba, 32'h5);
    checkOutput("full_wr_dout", io_dout, 8'hA5);
    strobeN(512, 0, n0, n1);
    checkOutput("full_wr_c1_cnt", n1, 512);
    checkOutput("full_wr_c0_cnt", n0, 0);
    finishBlock(d0, d1);
    checkOutput("full_wr_c1_done", d1, 1);
    checkOutput("full_wr_c0_done", d0, 0);
    c1_wr = 0;
    tick();

    $display("[TB] short read of 100 bytes");
    c0_rd = 1;
    waitIssue(own);
    strobeN(100, 1, n0, n1);
    checkOutput("short_c0_cnt", n0, 100);
    finishBlock(d0, d1);
    checkOutput("short_c0_done", d0, 1);
    c0_rd = 0;
    tick();

    $display("[TB] reset during transfer");
    c0_rd = 1;
    waitIssue(own);
    strobeN(200, 1, n0, n1);
    checkOutput("pre_reset_cnt", n0, 200);
    reset_n = 0;
    tick();
    checkOutput("mid_rst_io_rd", io_rd, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_owner", owner, 1);
    checkOutput("mid_rst_done", {c0_done, c1_done}, 0);
    reset_n = 1;
    io_ack = 0;
    c0_rd = 0;
    tick();
    checkOutput("post_rst_done", {c0_done, c1_done}, 0);
    checkOutput("post_rst_busy", busy, 0);
    c0_rd = 1;
    waitIssue(own);
    checkOutput("fresh_owner", own, 0);
    strobeN(30, 1, n0, n1);
    checkOutput("fresh_cnt", n0, 30);
    finishBlock(d0, d1);
    checkOutput("fresh_done", d0, 1);
    c0_rd = 0;
    tick();

    $display("[TB] round-robin with both requests held");
    resetDut();
    c0_rd = 1;
    c1_rd = 1;
    for (int t = 0; t < 4; t++) begin
      waitIssue(own);
      checkOutput($sformatf("rr%0d_owner", t), own, t % 2);
      strobeN(4, 1, n0, n1);
      checkOutput($sformatf("rr%0d_cnt", t), (t % 2 == 0) ? n0 : n1, 4);
      checkOutput($sformatf("rr%0d_other_cnt", t), (t % 2 == 0) ? n1 : n0, 0);
      finishBlock(d0, d1);
      checkOutput($sformatf("rr%0d_done", t), {d0, d1}, (t % 2 == 0) ? 2'b10 : 2'b01);
    end
    c0_rd = 0;
    c1_rd = 0;
    tick();

`ifdef SD_ARB_TIMEOUT_EN
    $display("[TB] watchdog abort with no ack");
    begin
      int hit_at;
      hit_at = -1;
      resetDut();
      c0_rd = 1;
      for (int i = 1; i <= 100 && hit_at < 0; i++) begin
        tick();
        if (err) begin
          hit_at = i;
          checkOutput("tmo_c0_done", c0_done, 1);
          checkOutput("tmo_io_rd", io_rd, 0);
          checkOutput("tmo_busy", busy, 0);
          c0_rd = 0;
        end
      end
      checkOutput("tmo_cycle", hit_at, 65);
      tick();
      checkOutput("tmo_err_pulse", err, 0);
      checkOutput("tmo_done_pulse", c0_done, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
